fsab_sram_target: RTL and testbench

On-chip FSAB memory target: consumes the arbitrated FSAB outbound request bus, services read and write bursts against a local synchronous SRAM, returns read data on the FSAB inbound bus tagged with the requester's DID/SUBDID, and returns one credit per completed request. It sits downstream of the FSAB arbiter as the responder end of the credit-based request protocol and is the bench/bring-up stand-in for the DDR controller.

---
 rtl/fsab_sram_target.sv | 243 ++++++++++++++++++++++++
 tb/tb_fsab_sram_target.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_sram_target.sv
// fsab_sram_target: FSAB responder that serves read/write bursts in arrival order from a local 64-bit SRAM.
// Latency: header at T -> engine pop T+1, first read beat T+3, credit at T+2+len for reads and writes.
// Backpressure: none on fsabo; flow control is by credits, and overflowing headers/beats are dropped and flag err.
// Optional: FSAB_SRAM_TARGET_BYTEMASK_EN enables per-byte write enables from fsabo_mask.
module fsab_sram_target #(
  parameter int CREDITS    = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_LEN    = 8,
  parameter int ADDR_W     = 31,
  parameter int DID_W      = 4,
  parameter int LEN_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsabo_valid,
  input  logic              fsabo_mode,
  input  logic [DID_W-1:0]  fsabo_did,
  input  logic [DID_W-1:0]  fsabo_subdid,
  input  logic [ADDR_W-1:0] fsabo_addr,
  input  logic [LEN_W-1:0]  fsabo_len,
  input  logic [63:0]       fsabo_data,
  input  logic [7:0]        fsabo_mask,
  output logic              fsabo_credit,
  output logic              fsabi_valid,
  output logic [DID_W-1:0]  fsabi_did,
  output logic [DID_W-1:0]  fsabi_subdid,
  output logic [63:0]       fsabi_data,
  output logic              err
);
  localparam int HDEPTH = CREDITS;
  localparam int DDEPTH = CREDITS * MAX_LEN;
  localparam int HPW    = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;
  localparam int DPW    = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
  localparam int HCW    = $clog2(HDEPTH + 1);
  localparam int DCW    = $clog2(DDEPTH + 1);
  localparam int WORDS  = 1 << DEPTH_LOG2;

  // Only the low DEPTH_LOG2 word-address bits matter: the array wraps.
  typedef struct packed {
    logic                  mode;
    logic [DID_W-1:0]      did;
    logic [DID_W-1:0]      subdid;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [LEN_W-1:0]      len;
  } hdr_t;

`ifdef FSAB_SRAM_TARGET_BYTEMASK_EN
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;
`else
  typedef struct packed {
    logic [63:0] data;
  } beat_t;
`endif

  typedef enum logic {T_HDR, T_DATA} trk_t;
  typedef enum logic [1:0] {E_IDLE, E_RD, E_WR} eng_t;

  trk_t                  trk;
  logic [LEN_W-1:0]      rem;
  logic                  drop;
  eng_t                  eng;
  logic [LEN_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DID_W-1:0]      cur_did;
  logic [DID_W-1:0]      cur_subdid;

  hdr_t             hmem [HDEPTH];
  logic [HPW-1:0]   hwp, hrp;
  logic [HCW-1:0]   hcnt;
  beat_t            dmem [DDEPTH];
  logic [DPW-1:0]   dwp, drp;
  logic [DCW-1:0]   dcnt;
  logic [63:0]      sram [WORDS];

  logic             hdr_beat, len_zero, len_big;
  logic [LEN_W-1:0] eff_len;
  logic             hpush_req, hpush, hpop, dpush_req, dpush, dpop;
  hdr_t             hin, hhead;
  beat_t            din, dhead;

`ifdef FSAB_SRAM_TARGET_BYTEMASK_EN
  logic unused_in;
  assign unused_in = ^{fsabo_addr[ADDR_W-1:DEPTH_LOG2+3], fsabo_addr[2:0]};
`else
  logic unused_in;
  assign unused_in = ^{fsabo_addr[ADDR_W-1:DEPTH_LOG2+3], fsabo_addr[2:0], fsabo_mask};
`endif

  // Request decode: length clamping and FIFO push/pop qualification (push into a full FIFO is allowed when it pops).
  always_comb begin
    hdr_beat  = fsabo_valid && (trk == T_HDR);
    len_zero  = (fsabo_len == '0);
    len_big   = (fsabo_len > LEN_W'(MAX_LEN));
    eff_len   = len_zero ? LEN_W'(1) : (len_big ? LEN_W'(MAX_LEN) : fsabo_len);
    hpop      = (eng == E_IDLE) && (hcnt != '0);
    hpush_req = hdr_beat;
    hpush     = hpush_req && ((hcnt != HCW'(HDEPTH)) || hpop);
    dpop      = (eng == E_WR) && (dcnt != '0);
    dpush_req = hdr_beat ? (fsabo_mode && hpush) : (fsabo_valid && !drop);
    dpush     = dpush_req && ((dcnt != DCW'(DDEPTH)) || dpop);
    hin        = '0;
    hin.mode   = fsabo_mode;
    hin.did    = fsabo_did;
    hin.subdid = fsabo_subdid;
    hin.waddr  = fsabo_addr[DEPTH_LOG2+2:3];
    hin.len    = eff_len;
    din        = '0;
    din.data   = fsabo_data;
`ifdef FSAB_SRAM_TARGET_BYTEMASK_EN
    din.mask   = fsabo_mask;
`endif
    hhead = hmem[hrp];
    dhead = dmem[drp];
  end

  // Input tracker: a write longer than one beat claims the next len-1 valid cycles as data beats.
  // Beats that belong to a dropped header are swallowed so they cannot pair with a later write.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk  <= T_HDR;
      rem  <= '0;
      drop <= 1'b0;
    end else if (hdr_beat) begin
      if (fsabo_mode && (eff_len > LEN_W'(1))) begin
        trk  <= T_DATA;
        rem  <= eff_len - LEN_W'(1);
        drop <= !hpush;
      end
    end else if (fsabo_valid) begin
      rem <= rem - LEN_W'(1);
      if (rem == LEN_W'(1)) trk <= T_HDR;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((hdr_beat && (len_zero || len_big)) || (hpush_req && !hpush) || (dpush_req && !dpush))
      err <= 1'b1;
  end

  // Header FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwp  <= '0;
      hrp  <= '0;
      hcnt <= '0;
    end else begin
      if (hpush) hwp <= (hwp == HPW'(HDEPTH - 1)) ? '0 : hwp + 1'b1;
      if (hpop)  hrp <= (hrp == HPW'(HDEPTH - 1)) ? '0 : hrp + 1'b1;
      hcnt <= hcnt + HCW'(hpush) - HCW'(hpop);
    end
  end

  // Header FIFO storage.
  always_ff @(posedge clk) begin
    if (hpush) hmem[hwp] <= hin;
  end

  // Write-data FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwp  <= '0;
      drp  <= '0;
      dcnt <= '0;
    end else begin
      if (dpush) dwp <= (dwp == DPW'(DDEPTH - 1)) ? '0 : dwp + 1'b1;
      if (dpop)  drp <= (drp == DPW'(DDEPTH - 1)) ? '0 : drp + 1'b1;
      dcnt <= dcnt + DCW'(dpush) - DCW'(dpop);
    end
  end

  // Write-data FIFO storage.
  always_ff @(posedge clk) begin
    if (dpush) dmem[dwp] <= din;
  end

  // SRAM write port: one beat per WR cycle when a data beat is available; contents survive rst.
  always_ff @(posedge clk) begin
    if (dpop) begin
`ifdef FSAB_SRAM_TARGET_BYTEMASK_EN
      for (int i = 0; i < 8; i++)
        if (dhead.mask[i]) sram[waddr][i*8 +: 8] <= dhead.data[i*8 +: 8];
`else
      sram[waddr] <= dhead.data;
`endif
    end
  end

  // Engine: in-order service; registered read port drives fsabi, credit on the last beat/write.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng          <= E_IDLE;
      cnt          <= '0;
      waddr        <= '0;
      cur_did      <= '0;
      cur_subdid   <= '0;
      fsabi_valid  <= 1'b0;
      fsabi_did    <= '0;
      fsabi_subdid <= '0;
      fsabi_data   <= '0;
      fsabo_credit <= 1'b0;
    end else begin
      fsabi_valid  <= 1'b0;
      fsabi_did    <= '0;
      fsabi_subdid <= '0;
      fsabo_credit <= 1'b0;
      case (eng)
        E_IDLE: if (hpop) begin
          eng        <= hhead.mode ? E_WR : E_RD;
          cnt        <= hhead.len;
          waddr      <= hhead.waddr;
          cur_did    <= hhead.did;
          cur_subdid <= hhead.subdid;
        end
        E_RD: begin
          fsabi_valid  <= 1'b1;
          fsabi_did    <= cur_did;
          fsabi_subdid <= cur_subdid;
          fsabi_data   <= sram[waddr];
          waddr        <= waddr + 1'b1;
          cnt          <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            eng          <= E_IDLE;
            fsabo_credit <= 1'b1;
          end
        end
        E_WR: if (dpop) begin
          waddr <= waddr + 1'b1;
          cnt   <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            eng          <= E_IDLE;
            fsabo_credit <= 1'b1;
          end
        end
        default: eng <= E_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsab_sram_target.sv
// tb_fsab_sram_target: directed bench for fsab_sram_target with a memory model and beat/credit scoreboards.
module tb_fsab_sram_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fsabo_valid = 1'b0;
  logic        fsabo_mode = 1'b0;
  logic [3:0]  fsabo_did = '0;
  logic [3:0]  fsabo_subdid = '0;
  logic [30:0] fsabo_addr = '0;
  logic [3:0]  fsabo_len = '0;
  logic [63:0] fsabo_data = '0;
  logic [7:0]  fsabo_mask = '0;
  logic        fsabo_credit, fsabi_valid, err;
  logic [3:0]  fsabi_did, fsabi_subdid;
  logic [63:0] fsabi_data;

  fsab_sram_target dut (
    .clk(clk), .rst(rst),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
    .fsabi_valid(fsabi_valid), .fsabi_did(fsabi_did), .fsabi_subdid(fsabi_subdid),
    .fsabi_data(fsabi_data), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  did;
    logic [3:0]  subdid;
    logic [63:0] data;
    int          at;
  } exp_beat_t;

  exp_beat_t   sb[$];
  int          cred_q[$];
  logic [63:0] mdl [int];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [3:0] l);
    if (l == 4'd0) return 1;
    if (l > 4'd8) return 8;
    return int'(l);
  endfunction

  function automatic int word_of(input logic [30:0] a, input int k);
    return (int'(a[30:3]) + k) % 1024;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] did, sub, input logic [30:0] addr, input logic [3:0] len,
                    input bit timed, input bit accepted);
    int t;
    int n;
    exp_beat_t b;
    t = cyc;
    n = eff(len);
    if (accepted) begin
      for (int k = 0; k < n; k++) begin
        b.did = did; b.subdid = sub; b.data = mdl[word_of(addr, k)];
        b.at = timed ? t + 3 + k : -1;
        sb.push_back(b);
      end
      cred_q.push_back(timed ? t + 2 + n : -1);
    end
    fsabo_valid = 1'b1; fsabo_mode = 1'b0; fsabo_did = did; fsabo_subdid = sub;
    fsabo_addr = addr; fsabo_len = len; fsabo_data = '0; fsabo_mask = '0;
    @(posedge clk); #1;
    fsabo_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] did, sub, input logic [30:0] addr, input int n,
                    input logic [63:0] base, input logic [7:0] mask, input bit timed);
    int t;
    int w;
    logic [63:0] v;
    logic [63:0] d;
    t = cyc;
    for (int k = 0; k < n; k++) begin
      w = word_of(addr, k);
      v = mdl.exists(w) ? mdl[w] : 64'h0;
      d = base + 64'(k);
`ifdef FSAB_SRAM_TARGET_BYTEMASK_EN
      for (int i = 0; i < 8; i++) if (mask[i]) v[i*8 +: 8] = d[i*8 +: 8];
`else
      v = d;
`endif
      mdl[w] = v;
    end
    cred_q.push_back(timed ? t + 2 + n : -1);
    for (int k = 0; k < n; k++) begin
      fsabo_valid = 1'b1; fsabo_mode = 1'b1; fsabo_did = did; fsabo_subdid = sub;
      fsabo_addr = addr; fsabo_len = 4'(n); fsabo_data = base + 64'(k); fsabo_mask = mask;
      @(posedge clk); #1;
    end
    fsabo_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_beats_left"}, 64'(sb.size()), 64'd0);
    chk({tag, "_credits_left"}, 64'(cred_q.size()), 64'd0);
  endtask

  // Output monitor: pops expected beats and credits as the DUT produces them.
  exp_beat_t mb;
  int        mc;
  always @(negedge clk) begin
    if (mon_en) begin
      if (fsabi_valid) begin
        chk("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mb = sb.pop_front();
          chk("beat_data", fsabi_data, mb.data);
          chk("beat_did", 64'(fsabi_did), 64'(mb.did));
          chk("beat_subdid", 64'(fsabi_subdid), 64'(mb.subdid));
          if (mb.at >= 0) chk("beat_cycle", 64'(cyc), 64'(mb.at));
        end
      end else begin
        chk("idle_ids_zero", 64'({fsabi_did, fsabi_subdid}), 64'd0);
      end
      if (fsabo_credit) begin
        chk("credit_expected", 64'(cred_q.size() != 0), 64'd1);
        if (cred_q.size() != 0) begin
          mc = cred_q.pop_front();
          if (mc >= 0) chk("credit_cycle", 64'(cyc), 64'(mc));
        end
      end
    end
  end

  initial begin
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(fsabi_valid), 64'd0);
    chk("rst_credit", 64'(fsabo_credit), 64'd0);
    chk("rst_did", 64'(fsabi_did), 64'd0);
    chk("rst_subdid", 64'(fsabi_subdid), 64'd0);
    chk("rst_data", fsabi_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Write 1..4 at 0x40 then read it back, both with exact timing.
    wr(4'd3, 4'd5, 31'h40, 4, 64'd1, 8'hFF, 1'b1);
    idle(10);
    drain("wr40");
    rd(4'd2, 4'd7, 31'h40, 4'd4, 1'b1, 1'b1);
    idle(10);
    drain("rd40");

    // Wrap at the array end; upper address bits and addr[2:0] are ignored.
    wr(4'd1, 4'd1, 31'h1FF8, 2, 64'hA5A5_0000_0000_1000, 8'hFF, 1'b1);
    idle(10);
    rd(4'd4, 4'd2, 31'h4000_1FFB, 4'd2, 1'b1, 1'b1);
    idle(10);
    drain("wrap");

    // Read queued ahead of a write to the same word sees the old value.
    wr(4'd5, 4'd0, 31'h200, 1, 64'h1111, 8'hFF, 1'b1);
    idle(8);
    rd(4'd6, 4'd1, 31'h200, 4'd1, 1'b0, 1'b1);
    wr(4'd7, 4'd2, 31'h200, 1, 64'h2222, 8'hFF, 1'b0);
    rd(4'd6, 4'd3, 31'h200, 4'd1, 1'b0, 1'b1);
    idle(20);
    drain("rbw");

    // Byte mask behaviour (the model follows the build configuration).
    wr(4'd1, 4'd0, 31'h300, 1, ones, 8'hFF, 1'b1);
    idle(6);
    wr(4'd1, 4'd0, 31'h300, 1, 64'h0, 8'h0F, 1'b1);
    idle(6);
    rd(4'd9, 4'd9, 31'h300, 4'd1, 1'b1, 1'b1);
    idle(8);
    wr(4'd1, 4'd0, 31'h300, 1, 64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1);
    idle(6);
    rd(4'd9, 4'd8, 31'h300, 4'd1, 1'b1, 1'b1);
    idle(8);
    drain("mask");
    chk("err_clean", 64'(err), 64'd0);

    // Busy len-8 read, four reads fill the header FIFO, a sixth header overflows.
    wr(4'd0, 4'd0, 31'h80, 8, 64'hC0DE_0000_0000_0000, 8'hFF, 1'b1);
    idle(12);
    rd(4'd8,  4'd0, 31'h80, 4'd8, 1'b0, 1'b1);
    rd(4'd9,  4'd1, 31'h40, 4'd1, 1'b0, 1'b1);
    rd(4'd10, 4'd2, 31'h48, 4'd1, 1'b0, 1'b1);
    rd(4'd11, 4'd3, 31'h50, 4'd1, 1'b0, 1'b1);
    rd(4'd12, 4'd4, 31'h58, 4'd1, 1'b0, 1'b1);
    rd(4'd13, 4'd5, 31'h200, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("overflow_err", 64'(err), 64'd1);
    idle(30);
    drain("fill");

    // Reset clears err.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_err", 64'(err), 64'd0);
    @(posedge clk); #1;

    // len = 0 is one beat and flags err; len = 12 is truncated to 8.
    rd(4'd1, 4'd2, 31'h40, 4'd0, 1'b1, 1'b1);
    idle(8);
    chk("len0_err", 64'(err), 64'd1);
    drain("len0");
    rd(4'd3, 4'd4, 31'h80, 4'd12, 1'b1, 1'b1);
    idle(14);
    drain("len_trunc");

    // Reset during the third beat of a len-8 read.
    rd(4'd5, 4'd6, 31'h80, 4'd8, 1'b1, 1'b1);
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    cred_q.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(fsabi_valid), 64'd0);
    chk("midrst_credit", 64'(fsabo_credit), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rd(4'd7, 4'd1, 31'h40, 4'd4, 1'b1, 1'b1);
    idle(12);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
